// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state/grant types and default widths for the SRAM arbiter.
package sram_arb_pkg;
    localparam int DEF_ADDR_W        = 21;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_ACCESS_CYCLES = 3;
    localparam int DEF_STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    typedef enum logic {GNT_CPU, GNT_LD} gnt_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU port, loader port and SRAM pad signals; slave = arbiter, master = environment.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              ld_req, ld_we, ld_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata, ld_rdata;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_dq_out, sram_dq_in;
    logic              sram_dq_oe, sram_n_ce, sram_n_oe, sram_n_we;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_we, ld_addr, ld_wdata, sram_dq_in,
        output cpu_rdata, cpu_ack, ld_rdata, ld_ack,
        output sram_a, sram_dq_out, sram_dq_oe, sram_n_ce, sram_n_oe, sram_n_we
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_we, ld_addr, ld_wdata, sram_dq_in,
        input  cpu_rdata, cpu_ack, ld_rdata, ld_ack,
        input  sram_a, sram_dq_out, sram_dq_oe, sram_n_ce, sram_n_oe, sram_n_we
    );
endinterface

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: CPU-over-loader priority decision and grant latch.
// SRAM_ARB_STARVE_GUARD_EN adds a saturating counter that forces a loader grant after STARVE_LIMIT CPU grants.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic n_reset,
    input  logic i_idle,
    input  logic i_cpu_req,
    input  logic i_ld_req,
    output gnt_t o_next,
    output gnt_t o_gnt
);
    if (STARVE_LIMIT < 1) begin : g_chk
        $error("STARVE_LIMIT must be >= 1");
    end

    logic w_starve;
    gnt_t r_gnt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] r_starve;

    assign w_starve = r_starve == SW'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            r_starve <= '0;
        else if (i_idle)
            r_starve <= (!i_ld_req || o_next == GNT_LD) ? '0 : w_starve ? r_starve : r_starve + 1'b1;
    end
`else
    assign w_starve = 1'b0;
`endif

    assign o_next = (i_ld_req && (!i_cpu_req || w_starve)) ? GNT_LD : GNT_CPU;
    assign o_gnt  = r_gnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            r_gnt <= GNT_CPU;
        else if (i_idle && (i_cpu_req || i_ld_req))
            r_gnt <= o_next;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the async SRAM bus between CPU and loader with registered setup/strobe/hold sequencing.
// Optional loader starvation guard: define SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           n_reset,
    sram_arbiter_if.slave  bus
);
    if (ACCESS_CYCLES < 1) begin : g_chk
        $error("ACCESS_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(ACCESS_CYCLES + 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_dq_out, r_cpu_rdata, r_ld_rdata;
    logic              r_dq_oe, r_n_ce, r_n_oe, r_n_we, r_cpu_ack, r_ld_ack;
    gnt_t              w_next, w_gnt;
    logic              w_idle, w_sel_ld, w_we;

    assign w_idle   = r_state == IDLE;
    assign w_sel_ld = w_next == GNT_LD;
    assign w_we     = w_sel_ld ? bus.ld_we : bus.cpu_we;

    sram_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_idle    (w_idle),
        .i_cpu_req (bus.cpu_req),
        .i_ld_req  (bus.ld_req),
        .o_next    (w_next),
        .o_gnt     (w_gnt)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_a         <= '0;
            r_dq_out    <= '0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
            r_dq_oe     <= 1'b0;
            r_n_ce      <= 1'b1;
            r_n_oe      <= 1'b1;
            r_n_we      <= 1'b1;
            r_cpu_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ld_ack  <= 1'b0;
            case (r_state)
                IDLE: if (bus.cpu_req || bus.ld_req) begin
                    r_state  <= SETUP;
                    r_we     <= w_we;
                    r_a      <= w_sel_ld ? bus.ld_addr : bus.cpu_addr;
                    r_dq_out <= w_sel_ld ? bus.ld_wdata : bus.cpu_wdata;
                    r_n_ce   <= 1'b0;
                    r_n_oe   <= w_we;
                    r_dq_oe  <= w_we;
                end
                SETUP: begin
                    r_state <= STROBE;
                    r_cnt   <= CW'(ACCESS_CYCLES - 1);
                    r_n_we  <= ~r_we;
                end
                STROBE: if (r_cnt == '0) begin
                    r_state   <= HOLD;
                    r_n_we    <= 1'b1;
                    r_n_oe    <= 1'b1;
                    r_cpu_ack <= w_gnt == GNT_CPU;
                    r_ld_ack  <= w_gnt == GNT_LD;
                    if (!r_we && w_gnt == GNT_CPU) r_cpu_rdata <= bus.sram_dq_in;
                    if (!r_we && w_gnt == GNT_LD)  r_ld_rdata  <= bus.sram_dq_in;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                HOLD: begin
                    r_state <= IDLE;
                    r_n_ce  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sram_a      = r_a;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_n_ce   = r_n_ce;
    assign bus.sram_n_oe   = r_n_oe;
    assign bus.sram_n_we   = r_n_we;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.ld_rdata    = r_ld_rdata;
    assign bus.cpu_ack     = r_cpu_ack;
    assign bus.ld_ack      = r_ld_ack;
endmodule
